// File: rtl/axi_lite_pkg.sv
// Shared types and constants for the AXI4-Lite command master.
// Holds the transaction FSM state encoding and the AXI response codes.
// No logic; imported by the master and its helpers.
package axi_lite_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    WR_RESP = 3'd2,
    RD_ADDR = 3'd3,
    RD_DATA = 3'd4,
    RSP     = 3'd5
  } state_t;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

endpackage

// File: rtl/counter.sv
// Free-running up counter with synchronous clear and count enable.
// Latency: count reflects clear/enable one cycle after they are sampled.
// No backpressure; wraps silently at 2**W.
module counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count
);

  // Clear has priority over counting; async reset for power-up state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (rst) begin
      count <= '0;
    end else if (en) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite master driven by a simple cmd/rsp handshake.
// Latency: 3 cycles cmd accept to rsp_valid with a zero-wait slave; timeout after TIMEOUT_CYCLES.
// Backpressure: cmd_ready only in IDLE; rsp held stable until rsp_ready.
module axi_lite_master
  import axi_lite_pkg::*;
#(
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 16,
  parameter int TIMEOUT_CYCLES     = 1024
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  // command side
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_wr,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  // response side
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                      rsp_resp,
  output logic                            rsp_timeout,
  // AXI4-Lite master
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  localparam int DW    = C_M_AXI_DATA_WIDTH;
  localparam int AW    = C_M_AXI_ADDR_WIDTH;
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t            state;
  logic [AW-1:0]     addr_q;
  logic [DW-1:0]     wdata_q;
  logic [DW/8-1:0]   wstrb_q;
  logic              aw_done;
  logic              w_done;

  logic              aw_hs;
  logic              w_hs;
  logic              wr_both;
  logic              timed;
  logic              state_entry;
  logic              tmo;
  logic [CNT_W-1:0]  tmo_count;

  // One address register serves both channels: only one transaction is ever in flight.
  assign M_AXI_AWADDR = addr_q;
  assign M_AXI_ARADDR = addr_q;
  assign M_AXI_WDATA  = wdata_q;
  assign M_AXI_WSTRB  = wstrb_q;

  // Handshake decode, and a pulse on the edge that moves the FSM into a waiting state
  // so the timeout count reads zero in the first cycle of that state.
  always_comb begin
    aw_hs       = M_AXI_AWVALID & M_AXI_AWREADY;
    w_hs        = M_AXI_WVALID & M_AXI_WREADY;
    wr_both     = (aw_done | aw_hs) & (w_done | w_hs);
    timed       = (state == WR) || (state == WR_RESP) ||
                  (state == RD_ADDR) || (state == RD_DATA);
    tmo         = timed && (tmo_count == TMO_LAST);
    state_entry = 1'b0;
    case (state)
      IDLE:    state_entry = cmd_ready & cmd_valid;
      WR:      state_entry = wr_both;
      RD_ADDR: state_entry = M_AXI_ARVALID & M_AXI_ARREADY;
      default: state_entry = 1'b0;
    endcase
  end

  counter #(.W(CNT_W)) u_tmo (
    .clk   (S_AXI_ACLK),
    .rst_n (S_AXI_ARESETN),
    .rst   (state_entry | ~S_AXI_ARESETN),
    .en    (timed),
    .count (tmo_count)
  );

  // Transaction FSM; every handshake output is a flop. A completing handshake is
  // always checked before the timeout so it wins a same-cycle tie.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state         <= IDLE;
      cmd_ready     <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_resp      <= OKAY;
      rsp_timeout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_ready && cmd_valid) begin
            cmd_ready <= 1'b0;
            addr_q    <= cmd_addr;
            if (cmd_wr) begin
              wdata_q       <= cmd_wdata;
              wstrb_q       <= cmd_wstrb;
              aw_done       <= 1'b0;
              w_done        <= 1'b0;
              M_AXI_AWVALID <= 1'b1;
              M_AXI_WVALID  <= 1'b1;
              state         <= WR;
            end else begin
              M_AXI_ARVALID <= 1'b1;
              state         <= RD_ADDR;
            end
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        WR: begin
          if (aw_hs) begin
            M_AXI_AWVALID <= 1'b0;
            aw_done       <= 1'b1;
          end
          if (w_hs) begin
            M_AXI_WVALID <= 1'b0;
            w_done       <= 1'b1;
          end
          if (wr_both) begin
            M_AXI_BREADY <= 1'b1;
            state        <= WR_RESP;
          end else if (tmo) begin
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WVALID  <= 1'b0;
            rsp_valid     <= 1'b1;
            rsp_rdata     <= '0;
            rsp_resp      <= SLVERR;
            rsp_timeout   <= 1'b1;
            state         <= RSP;
          end
        end
        WR_RESP: begin
          if (M_AXI_BVALID) begin
            M_AXI_BREADY <= 1'b0;
            rsp_valid    <= 1'b1;
            rsp_rdata    <= '0;
            rsp_resp     <= M_AXI_BRESP;
            rsp_timeout  <= 1'b0;
            state        <= RSP;
          end else if (tmo) begin
            M_AXI_BREADY <= 1'b0;
            rsp_valid    <= 1'b1;
            rsp_rdata    <= '0;
            rsp_resp     <= SLVERR;
            rsp_timeout  <= 1'b1;
            state        <= RSP;
          end
        end
        RD_ADDR: begin
          if (M_AXI_ARREADY) begin
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b1;
            state         <= RD_DATA;
          end else if (tmo) begin
            M_AXI_ARVALID <= 1'b0;
            rsp_valid     <= 1'b1;
            rsp_rdata     <= '0;
            rsp_resp      <= SLVERR;
            rsp_timeout   <= 1'b1;
            state         <= RSP;
          end
        end
        RD_DATA: begin
          if (M_AXI_RVALID) begin
            M_AXI_RREADY <= 1'b0;
            rsp_valid    <= 1'b1;
            rsp_rdata    <= M_AXI_RDATA;
            rsp_resp     <= M_AXI_RRESP;
            rsp_timeout  <= 1'b0;
            state        <= RSP;
          end else if (tmo) begin
            M_AXI_RREADY <= 1'b0;
            rsp_valid    <= 1'b1;
            rsp_rdata    <= '0;
            rsp_resp     <= SLVERR;
            rsp_timeout  <= 1'b1;
            state        <= RSP;
          end
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid   <= 1'b0;
            rsp_timeout <= 1'b0;
            cmd_ready   <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_master.sv
// Directed bench for axi_lite_master with a configurable AXI-Lite slave model.
// Expected responses are queued at issue time and checked by a separate monitor.
// Inputs change on the falling edge; outputs are sampled away from the rising edge.
module tb_axi_lite_master;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic        tmo;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_wr;
  logic [15:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [15:0] M_AXI_AWADDR, M_AXI_ARADDR;
  logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
  logic [31:0] M_AXI_WDATA, M_AXI_RDATA;
  logic [3:0]  M_AXI_WSTRB;
  logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;
  logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
  logic        M_AXI_RVALID, M_AXI_RREADY;

  int total = 0;
  int bad   = 0;
  exp_t exp_q[$];

  // slave model settings
  int          aw_lat = 0, w_lat = 0, ar_lat = 0, r_lat = 0, b_lat = 0;
  bit          ar_never = 0, b_never = 0;
  logic [31:0] s_rdata = 32'h0;
  logic [1:0]  s_rresp = 2'b00, s_bresp = 2'b00;
  int          aw_hs_n = 0, w_hs_n = 0, b_hs_n = 0;

  axi_lite_master #(
    .C_M_AXI_DATA_WIDTH(32),
    .C_M_AXI_ADDR_WIDTH(16),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WVALID(M_AXI_WVALID),
    .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RVALID(M_AXI_RVALID),
    .M_AXI_RREADY(M_AXI_RREADY)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%b required=%b", name, act, req);
    end
  endtask

  // Drive one command; returns #1 after the accepting rising edge (cycle 0 ends there).
  task automatic send(input logic wr, input logic [15:0] addr, input logic [31:0] wd,
                      input logic [3:0] ws, input bit push, input exp_t e);
    int n;
    if (push) exp_q.push_back(e);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = ws;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk1("cmd_accept", cmd_ready, 1'b1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !cmd_ready) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk1({name, "_done"}, n < 400, 1'b1);
  endtask

  // AXI-Lite slave: each READY/VALID decision is made on the falling edge.
  initial begin : slave
    int aw_c, w_c, ar_c, r_c, b_c;
    aw_c = 0; w_c = 0; ar_c = 0; r_c = 0; b_c = 0;
    M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_ARREADY = 0;
    M_AXI_BVALID = 0; M_AXI_RVALID = 0;
    M_AXI_BRESP = 0; M_AXI_RRESP = 0; M_AXI_RDATA = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_ARREADY = 0;
        M_AXI_BVALID = 0; M_AXI_RVALID = 0;
        aw_c = 0; w_c = 0; ar_c = 0; r_c = 0; b_c = 0;
      end else begin
        if (M_AXI_AWVALID) begin M_AXI_AWREADY = (aw_c >= aw_lat); aw_c++; end
        else begin M_AXI_AWREADY = 0; aw_c = 0; end
        if (M_AXI_WVALID) begin M_AXI_WREADY = (w_c >= w_lat); w_c++; end
        else begin M_AXI_WREADY = 0; w_c = 0; end
        if (M_AXI_ARVALID) begin M_AXI_ARREADY = !ar_never && (ar_c >= ar_lat); ar_c++; end
        else begin M_AXI_ARREADY = 0; ar_c = 0; end
        if (M_AXI_BREADY) begin
          M_AXI_BVALID = !b_never && (b_c >= b_lat);
          M_AXI_BRESP  = M_AXI_BVALID ? s_bresp : 2'b11;
          b_c++;
        end else begin M_AXI_BVALID = 0; b_c = 0; end
        if (M_AXI_RREADY) begin
          M_AXI_RVALID = (r_c >= r_lat);
          M_AXI_RDATA  = M_AXI_RVALID ? s_rdata : 32'hFFFF0000;
          M_AXI_RRESP  = M_AXI_RVALID ? s_rresp : 2'b11;
          r_c++;
        end else begin M_AXI_RVALID = 0; r_c = 0; end
      end
    end
  end

  // Handshake counters: valid&&ready seen after the falling edge completes on the next rise.
  initial begin : hs_count
    forever begin
      @(negedge clk);
      #1;
      if (rst_n) begin
        if (M_AXI_AWVALID && M_AXI_AWREADY) aw_hs_n++;
        if (M_AXI_WVALID && M_AXI_WREADY)   w_hs_n++;
        if (M_AXI_BVALID && M_AXI_BREADY)   b_hs_n++;
      end
    end
  end

  // Scoreboard monitor: every accepted response is matched against the queue head.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_rsp actual=rsp rdata=%h resp=%b required=no response", rsp_rdata, rsp_resp);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_resp", 32'(rsp_resp), 32'(e.resp));
          chk1("rsp_timeout", rsp_timeout, e.tmo);
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog actual=still running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n, a0, w0, b0;
    rst_n = 1'b0; cmd_valid = 0; cmd_wr = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
    rsp_ready = 1'b1;

    // reset state
    repeat (3) @(negedge clk);
    chk1("rst_cmd_ready", cmd_ready, 1'b0);
    chk1("rst_awvalid", M_AXI_AWVALID, 1'b0);
    chk1("rst_arvalid", M_AXI_ARVALID, 1'b0);
    chk1("rst_bready", M_AXI_BREADY, 1'b0);
    chk1("rst_rsp_valid", rsp_valid, 1'b0);
    chk1("rst_rsp_timeout", rsp_timeout, 1'b0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk1("post_rst_cmd_ready", cmd_ready, 1'b1);

    // zero-wait write: 3-cycle latency, rdata forced to 0
    send(1'b1, 16'h0004, 32'hDEADBEEF, 4'hF, 1, exp_t'{32'h0, 2'b00, 1'b0});
    @(negedge clk);
    chk("wr_awaddr", 32'(M_AXI_AWADDR), 32'h0004);
    chk("wr_wdata", M_AXI_WDATA, 32'hDEADBEEF);
    chk("wr_wstrb", 32'(M_AXI_WSTRB), 32'hF);
    chk1("wr_awvalid_c1", M_AXI_AWVALID, 1'b1);
    chk1("wr_wvalid_c1", M_AXI_WVALID, 1'b1);
    @(negedge clk);
    chk1("wr_rsp_valid_c2", rsp_valid, 1'b0);
    chk1("wr_bready_c2", M_AXI_BREADY, 1'b1);
    @(negedge clk);
    chk1("wr_rsp_valid_c3", rsp_valid, 1'b1);
    wait_done("wr");

    // read with 5 stall cycles on R
    r_lat = 5; s_rdata = 32'h12345678; s_rresp = 2'b00;
    send(1'b0, 16'h0010, 32'h0, 4'h0, 1, exp_t'{32'h12345678, 2'b00, 1'b0});
    @(negedge clk);
    chk("rd_araddr", 32'(M_AXI_ARADDR), 32'h0010);
    chk1("rd_arvalid_c1", M_AXI_ARVALID, 1'b1);
    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (M_AXI_RREADY) n++;
      if (rsp_valid) break;
    end
    chk("rd_rready_cycles", n, 6);
    wait_done("rd");
    r_lat = 0;

    // skewed write channels: W accepted 4 cycles before AW, SLVERR on B
    aw_lat = 4; s_bresp = 2'b10;
    a0 = aw_hs_n; w0 = w_hs_n; b0 = b_hs_n;
    send(1'b1, 16'h0008, 32'h01020304, 4'h3, 1, exp_t'{32'h0, 2'b10, 1'b0});
    @(negedge clk);
    @(negedge clk);
    chk1("skew_wvalid_dropped", M_AXI_WVALID, 1'b0);
    chk1("skew_awvalid_held", M_AXI_AWVALID, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk1("skew_awvalid_c4", M_AXI_AWVALID, 1'b1);
    chk("skew_wstrb", 32'(M_AXI_WSTRB), 32'h3);
    wait_done("skew");
    chk("skew_aw_beats", aw_hs_n - a0, 1);
    chk("skew_w_beats", w_hs_n - w0, 1);
    chk("skew_b_beats", b_hs_n - b0, 1);
    aw_lat = 0; s_bresp = 2'b00;

    // ARREADY arrives in the same cycle as the timeout: handshake wins
    ar_lat = 15; s_rdata = 32'h0BADF00D;
    send(1'b0, 16'h0030, 32'h0, 4'h0, 1, exp_t'{32'h0BADF00D, 2'b00, 1'b0});
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (M_AXI_ARVALID) n++; else break;
    end
    chk("tie_arvalid_cycles", n, 16);
    chk1("tie_rready", M_AXI_RREADY, 1'b1);
    wait_done("tie");
    ar_lat = 0;

    // AR timeout: ARVALID held exactly 16 cycles, then SLVERR + timeout flag
    ar_never = 1;
    send(1'b0, 16'h0020, 32'h0, 4'h0, 1, exp_t'{32'h0, 2'b10, 1'b1});
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (M_AXI_ARVALID) n++; else break;
    end
    chk("tmo_arvalid_cycles", n, 16);
    chk1("tmo_rready", M_AXI_RREADY, 1'b0);
    wait_done("tmo_ar");
    ar_never = 0;

    // B never arrives: timeout in WR_RESP, and no late B is accepted
    b_never = 1; b0 = b_hs_n;
    send(1'b1, 16'h0040, 32'h55AA55AA, 4'hF, 1, exp_t'{32'h0, 2'b10, 1'b1});
    wait_done("tmo_b");
    b_never = 0;
    repeat (3) @(negedge clk);
    chk("tmo_b_no_late_beat", b_hs_n - b0, 0);

    // response back-pressure for 10 cycles
    @(negedge clk);
    rsp_ready = 1'b0; s_rdata = 32'hA5A55A5A;
    send(1'b0, 16'h0050, 32'h0, 4'h0, 1, exp_t'{32'hA5A55A5A, 2'b00, 1'b0});
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      chk1("bp_rsp_valid", rsp_valid, 1'b1);
      chk("bp_rsp_rdata", rsp_rdata, 32'hA5A55A5A);
      chk("bp_rsp_resp", 32'(rsp_resp), 32'h0);
      chk1("bp_cmd_ready", cmd_ready, 1'b0);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    wait_done("bp");

    // reset pulse while waiting in WR_RESP: abort, no response
    b_never = 1;
    send(1'b1, 16'h0060, 32'h99999999, 4'hF, 0, exp_t'{32'h0, 2'b00, 1'b0});
    n = 0;
    while (!M_AXI_BREADY && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk1("abort_in_wr_resp", M_AXI_BREADY, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk1("abort_bready", M_AXI_BREADY, 1'b0);
    chk1("abort_awvalid", M_AXI_AWVALID, 1'b0);
    chk1("abort_wvalid", M_AXI_WVALID, 1'b0);
    chk1("abort_arvalid", M_AXI_ARVALID, 1'b0);
    chk1("abort_rready", M_AXI_RREADY, 1'b0);
    chk1("abort_rsp_valid", rsp_valid, 1'b0);
    chk1("abort_cmd_ready", cmd_ready, 1'b0);
    repeat (2) @(negedge clk);
    chk1("abort_cmd_ready_held", cmd_ready, 1'b0);
    b_never = 0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk1("abort_release_cmd_ready", cmd_ready, 1'b1);
    chk1("abort_release_rsp_valid", rsp_valid, 1'b0);

    // recovery write after the abort
    send(1'b1, 16'h0004, 32'h11111111, 4'hF, 1, exp_t'{32'h0, 2'b00, 1'b0});
    wait_done("recover");
    chk("queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_lite_master.md
AXI_LITE_MASTER -- requirements
Module: axi_lite_master

Interface
REQ-001 SHALL have parameter C_M_AXI_DATA_WIDTH, default 32, meaning data bus width.
REQ-002 SHALL have parameter C_M_AXI_ADDR_WIDTH, default 16, meaning address bus width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning the maximum number of cycles the block waits for any slave handshake.
REQ-004 SHALL have one clock and an asynchronous active-low reset:
- S_AXI_ACLK  in  1  clock
- S_AXI_ARESETN  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted
- cmd_wr  in  1  1=write, 0=read
- cmd_addr  in  ADDR  byte address
- cmd_wdata  in  DATA  write data
- cmd_wstrb  in  DATA/8  write strobes
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed
- rsp_rdata  out  DATA  read data (0 for writes)
- rsp_resp  out  2  BRESP/RRESP, or 2'b10 on timeout
- rsp_timeout  out  1  transaction timed out
- M_AXI_AWADDR/AWVALID/AWREADY, WDATA/WSTRB/WVALID/WREADY, BRESP/BVALID/BREADY, ARADDR/ARVALID/ARREADY, RDATA/RRESP/RVALID/RREADY  standard AXI4-Lite master directions and widths.

Function
REQ-005 SHALL implement the FSM states IDLE, WR, WR_RESP, RD_ADDR, RD_DATA and RSP, with one transaction outstanding at most.
REQ-006 SHALL assert cmd_ready only in IDLE; a command is accepted on cmd_valid&&cmd_ready and its fields are registered.
REQ-007 On an accepted write, the FSM SHALL enter WR; AWVALID and WVALID SHALL both rise on the next cycle.
REQ-008 In WR, AWVALID and WVALID SHALL each drop independently the cycle after their own handshake; the FSM SHALL go to WR_RESP once both handshakes are done, including when both occur in the same cycle.
REQ-009 SHALL assert BREADY only in WR_RESP; on BVALID the FSM SHALL capture BRESP, force rsp_rdata to 0 and go to RSP.
REQ-010 On an accepted read, the FSM SHALL enter RD_ADDR with ARVALID high from the next cycle; it SHALL drop ARVALID on ARREADY and go to RD_DATA.
REQ-011 SHALL assert RREADY only in RD_DATA; on RVALID the FSM SHALL capture RDATA and RRESP and go to RSP.
REQ-012 In RSP, rsp_valid SHALL be high and all rsp_* outputs SHALL stay stable until rsp_ready; the FSM SHALL return to IDLE the cycle after rsp_ready.
REQ-013 Minimum write latency SHALL be 3 cycles from cmd accept to rsp_valid, given AWREADY=WREADY=1 at the first valid and BVALID in the next cycle; minimum read latency SHALL likewise be 3 cycles.
REQ-014 Outgoing AXI address/data/strobe outputs SHALL remain stable while their VALID is high (no change before the handshake).
REQ-015 A timeout counter SHALL clear on entry to WR, WR_RESP, RD_ADDR and RD_DATA and count in those states; on reaching TIMEOUT_CYCLES-1 without the awaited handshake, the block SHALL drop all VALID and READY outputs and go to RSP with rsp_resp=2'b10, rsp_timeout=1 and rsp_rdata=0.
REQ-016 A handshake that arrives in the same cycle as the timeout SHALL win: the transaction completes normally.
REQ-017 SHALL ignore any late B or R beat after a timeout, because BREADY and RREADY stay low outside WR_RESP and RD_DATA.
REQ-018 SHALL ignore cmd_valid outside IDLE.

Reset
REQ-019 While S_AXI_ARESETN=0, the FSM SHALL be in IDLE, and all VALID/READY outputs, rsp_valid, rsp_timeout and the counter SHALL be 0.
REQ-020 During reset, cmd_ready SHALL be 0; it SHALL rise in the first cycle after deassertion.
REQ-021 A reset asserted mid-transaction SHALL abort the transaction immediately, with no response generated.
REQ-022 Data and address registers SHALL reset to 0.

Structure
REQ-023 A shared package (axi_lite_pkg) SHALL hold the FSM state enum and the response constants OKAY=2'b00 and SLVERR=2'b10.
REQ-024 The timeout SHALL reuse the existing counter sub-module (counter), with its rst driven by the FSM state-entry pulse OR'd with reset; no other sub-module.

Verification
REQ-025 The bench SHALL cover a write: write 0x0004←0xDEADBEEF, wstrb 0xF, slave ready immediately -> AWADDR=0x0004, WDATA=0xDEADBEEF, rsp_valid at cycle 3, rsp_resp=00, rsp_rdata=0.
REQ-026 The bench SHALL cover a read: read 0x0010, slave returns 0x12345678 after 5 stall cycles -> rsp_rdata=0x12345678, rsp_resp=00, rsp_timeout=0.
REQ-027 The bench SHALL cover skewed channels: WREADY 4 cycles before AWREADY -> WVALID drops after 1 beat, AWVALID holds, exactly one B accepted.
REQ-028 The bench SHALL cover a timeout: TIMEOUT_CYCLES=16, slave never asserts ARREADY -> ARVALID drops after 16 cycles, rsp_resp=10, rsp_timeout=1.
REQ-029 The bench SHALL cover response back-pressure: rsp_ready low for 10 cycles -> rsp fields stable and cmd_ready=0 throughout.
REQ-030 The bench SHALL cover a reset abort: S_AXI_ARESETN pulsed low in WR_RESP -> all VALID/READY outputs 0 asynchronously, and cmd_ready=1 the first cycle after release.
